// File: rtl/ifetch.sv
// ifetch: 32-bit instruction fetch feeding a 16-bit parcel prefetch queue.
// Optional feature: define IFETCH_BYPASS_EN for same-cycle ack-to-decoder bypass.
module ifetch #(
   parameter int unsigned   RV       = 32,
   parameter int unsigned   QDEPTH   = 4,
   parameter logic [RV-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          redirect,
   input  logic [RV-1:0] redirect_pc,
   output logic          mem_req,
   output logic [RV-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_err,
   output logic [15:0]   ins,
   output logic          idone,
   output logic [RV-1:0] ins_pc,
   output logic          ifault
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_e;

   state_e            state_q, state_d;
   logic [RV-1:0]     fpc_q, fpc_d;
   logic [RV-1:0]     addr_q, addr_d;
   logic              discard_q, discard_d;
   logic              halt_q, halt_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [AW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [15:0]       par_q [QDEPTH];
   logic [RV-1:0]     pcq_q [QDEPTH];
   logic [QDEPTH-1:0] flt_q;

   logic              empty;
   logic              ack_ok;
   logic              byp;
   logic              pop;
   logic              busy;
   logic              issue;
   logic [1:0]        n_push;
   logic [CW-1:0]     cnt_after;
   logic [AW-1:0]     wr1;
   logic [15:0]       e0_par, e1_par, w0_par;
   logic [RV-1:0]     e0_pc, e1_pc, w0_pc;

   // Queue bookkeeping: accepted ack, bypass, pop and push counts.
   always_comb begin
      empty  = (cnt_q == '0);
      ack_ok = (state_q == S_REQ) && mem_ack
               && !discard_q && !redirect;
      e0_par = fpc_q[1] ? mem_rdata[31:16]
                        : mem_rdata[15:0];
      e0_pc  = fpc_q;
      e1_par = mem_rdata[31:16];
      e1_pc  = fpc_q + RV'(2);
`ifdef IFETCH_BYPASS_EN
      byp    = ack_ok && empty && !stall;
`else
      byp    = 1'b0;
`endif
      idone  = (!empty || byp) && !stall && !redirect;
      pop    = idone && !empty;
      n_push = 2'd0;
      if (ack_ok) begin
         n_push = (fpc_q[1] ? 2'd1 : 2'd2)
                  - {1'b0, byp};
      end
      w0_par = byp ? e1_par : e0_par;
      w0_pc  = byp ? e1_pc  : e0_pc;
      wr1    = wr_q + AW'(1);
      ins    = byp ? e0_par : par_q[rd_q];
      ins_pc = byp ? e0_pc  : pcq_q[rd_q];
      ifault = byp ? mem_err : flt_q[rd_q];
      if (redirect) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         rd_d  = rd_q + AW'(pop);
         wr_d  = wr_q + AW'(n_push);
         cnt_d = cnt_q + CW'(n_push) - CW'(pop);
      end
   end

   // Request FSM next state, fetch PC, discard and fault-halt flags.
   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      addr_d    = addr_q;
      discard_d = discard_q;
      halt_d    = halt_q;
      busy      = (state_q == S_REQ) && !mem_ack;
      if (redirect) begin
         fpc_d  = redirect_pc & ~RV'(1);
         halt_d = 1'b0;
      end else if (ack_ok) begin
         fpc_d  = {fpc_q[RV-1:2] + (RV-2)'(1), 2'b00};
         halt_d = halt_q | mem_err;
      end
      if ((state_q == S_REQ) && mem_ack) begin
         discard_d = 1'b0;
      end
      if (redirect && busy) begin
         discard_d = 1'b1;
      end
      cnt_after = cnt_d;
      issue     = !busy && !halt_d
                  && (cnt_after <= CW'(QDEPTH - 2));
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = issue ? S_REQ : S_IDLE;
            end
         end
      endcase
      if (issue) begin
         addr_d = {fpc_d[RV-1:2], 2'b00};
      end
   end

   assign mem_req  = (state_q == S_REQ);
   assign mem_addr = addr_q;

   // Control state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         fpc_q     <= RESET_PC;
         addr_q    <= {RESET_PC[RV-1:2], 2'b00};
         discard_q <= 1'b0;
         halt_q    <= 1'b0;
         rd_q      <= '0;
         wr_q      <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         fpc_q     <= fpc_d;
         addr_q    <= addr_d;
         discard_q <= discard_d;
         halt_q    <= halt_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
      end
   end

   // Parcel storage; up to two entries written per accepted ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(QDEPTH); i++) begin
            par_q[i] <= '0;
            pcq_q[i] <= '0;
         end
         flt_q <= '0;
      end else begin
         if (n_push != 2'd0) begin
            par_q[wr_q] <= w0_par;
            pcq_q[wr_q] <= w0_pc;
            flt_q[wr_q] <= mem_err;
         end
         if (n_push == 2'd2) begin
            par_q[wr1] <= e1_par;
            pcq_q[wr1] <= e1_pc;
            flt_q[wr1] <= mem_err;
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed and random checks of ifetch against a
// sequential-halfword instruction stream model.
module tb_ifetch;

   localparam int RV = 32;
`ifdef IFETCH_BYPASS_EN
   localparam int BYP_LAT = 0;
`else
   localparam int BYP_LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          redirect = 1'b0;
   logic [RV-1:0] redirect_pc = '0;
   logic          mem_req;
   logic [RV-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          mem_err = 1'b0;
   logic [15:0]   ins;
   logic          idone;
   logic [RV-1:0] ins_pc;
   logic          ifault;

   ifetch #(.RV(RV), .QDEPTH(4), .RESET_PC('0)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .mem_err(mem_err),
      .ins(ins),
      .idone(idone),
      .ins_pc(ins_pc),
      .ifault(ifault)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail = 0;
   int          cycnum = 0;
   bit          pend = 0;
   int          lat = 0;
   int          lat_fix = -1;
   logic [31:0] addr_l = '0;
   logic [31:0] exp_pc = '0;
   bit          err_en = 0;
   logic [31:0] err_addr = '0;
   bit          stray_ack = 0;
   logic [31:0] req_addr [$];
   logic [31:0] del_pc [$];
   logic [15:0] del_ins [$];
   bit          del_flt [$];
   int          del_cyc [$];
   int          ack_log [$];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h0) return 32'h4433_0211;
      if (a == 32'h300) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3
             ^ {a[15:0], a[31:16]};
   endfunction

   function automatic bit errfn(input logic [31:0] a);
      return err_en && (a == err_addr);
   endfunction

   function automatic logic [15:0] parcel(input logic [31:0] pc);
      logic [31:0] w;
      w = memfn({pc[31:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: called just after a negedge, returns at the next.
   task automatic cyc(input bit st, input bit rd,
                      input logic [31:0] rpc);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      mem_err     = 1'b0;
      if (pend) begin
         chk("req_held", {31'b0, mem_req}, 32'h1);
         chk("addr_held", mem_addr, addr_l);
      end else if (mem_req) begin
         pend   = 1;
         addr_l = mem_addr;
         lat    = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
         req_addr.push_back(mem_addr);
         chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      end else if (stray_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end
      if (pend) begin
         if (lat == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = memfn(addr_l);
            mem_err   = errfn(addr_l);
            pend      = 0;
            ack_log.push_back(cycnum);
         end else begin
            lat--;
         end
      end
      #1;
      if (rd) chk("idone_on_redirect", {31'b0, idone}, 32'h0);
      if (idone) begin
         chk("ins_pc", ins_pc, exp_pc);
         chk("ins", {16'b0, ins}, {16'b0, parcel(exp_pc)});
         chk("ifault", {31'b0, ifault},
             {31'b0, errfn({exp_pc[31:2], 2'b00})});
         del_pc.push_back(ins_pc);
         del_ins.push_back(ins);
         del_flt.push_back(ifault);
         del_cyc.push_back(cycnum);
         exp_pc = exp_pc + 32'd2;
      end
      @(posedge clk);
      if (rd) exp_pc = rpc & ~32'h1;
      @(negedge clk);
      cycnum++;
   endtask

   initial begin
      int          mr;
      int          md;
      bit          found;
      logic [31:0] w;

      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_idone", {31'b0, idone}, 32'h0);
      chk("rst_ins", {16'b0, ins}, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      chk("rst_ifault", {31'b0, ifault}, 32'h0);
      @(negedge clk);

      // first fetch after reset, two wait cycles
      reset   = 1'b1;
      lat_fix = 2;
      exp_pc  = 32'h0;
      repeat (10) cyc(0, 0, '0);
      chk("t1_req0", req_addr[0], 32'h0);
      chk("t1_pc0", del_pc[0], 32'h0);
      chk("t1_ins0", {16'b0, del_ins[0]}, 32'h0211);
      chk("t1_pc1", del_pc[1], 32'h2);
      chk("t1_ins1", {16'b0, del_ins[1]}, 32'h4433);
      chk("t1_consec", del_cyc[1] - del_cyc[0], 32'd1);
      chk("t1_ack_lat", del_cyc[0] - ack_log[0], BYP_LAT);

      // redirect to an odd halfword
      lat_fix = -1;
      cyc(0, 1, 32'h106);
      mr = req_addr.size();
      md = del_pc.size();
      repeat (12) cyc(0, 0, '0);
      w = memfn(32'h104);
      chk("t2_req0", req_addr[mr], 32'h104);
      chk("t2_req1", req_addr[mr+1], 32'h108);
      chk("t2_pc0", del_pc[md], 32'h106);
      chk("t2_ins0", {16'b0, del_ins[md]}, {16'b0, w[31:16]});
      chk("t2_pc1", del_pc[md+1], 32'h108);

      // long stall fills the queue without overflow
      lat_fix = 1;
      cyc(1, 1, 32'h200);
      mr = req_addr.size();
      md = del_pc.size();
      repeat (10) cyc(1, 0, '0);
      chk("t3_nreq", req_addr.size() - mr, 32'd2);
      chk("t3_req_idle", {31'b0, mem_req}, 32'h0);
      chk("t3_no_del", del_pc.size() - md, 32'd0);
      repeat (8) cyc(0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         chk("t3_order", del_pc[md+i], 32'h200 + 32'(2 * i));
      end

      // redirect while a request is outstanding
      lat_fix = 3;
      cyc(1, 1, 32'h300);
      found = 0;
      for (int j = 0; j < 20; j++) begin
         if (!found) begin
            cyc(1, 0, '0);
            if (pend && addr_l == 32'h300) found = 1;
         end
      end
      chk("t4_found", {31'b0, found}, 32'h1);
      cyc(0, 1, 32'h500);
      mr = req_addr.size();
      md = del_pc.size();
      repeat (14) cyc(0, 0, '0);
      w = memfn(32'h500);
      chk("t4_req0", req_addr[mr], 32'h500);
      chk("t4_pc0", del_pc[md], 32'h500);
      chk("t4_ins0", {16'b0, del_ins[md]}, {16'b0, w[15:0]});

      // bus error stops fetching until redirect
      lat_fix  = -1;
      err_en   = 1;
      err_addr = 32'h20;
      cyc(0, 1, 32'h20);
      mr = req_addr.size();
      md = del_pc.size();
      repeat (16) cyc(0, 0, '0);
      chk("t5_nreq", req_addr.size() - mr, 32'd1);
      chk("t5_req0", req_addr[mr], 32'h20);
      chk("t5_ndel", del_pc.size() - md, 32'd2);
      chk("t5_flt0", {31'b0, del_flt[md]}, 32'h1);
      chk("t5_flt1", {31'b0, del_flt[md+1]}, 32'h1);
      chk("t5_req_idle", {31'b0, mem_req}, 32'h0);
      err_en = 0;
      cyc(0, 1, 32'h40);
      chk("t5_restart", {31'b0, mem_req}, 32'h1);
      chk("t5_restart_addr", mem_addr, 32'h40);

      // reset in the middle of a transaction
      lat_fix = 3;
      cyc(0, 0, '0);
      chk("t6_pend", {31'b0, pend}, 32'h1);
      reset = 1'b0;
      #1;
      chk("t6_req", {31'b0, mem_req}, 32'h0);
      chk("t6_addr", mem_addr, 32'h0);
      chk("t6_idone", {31'b0, idone}, 32'h0);
      pend    = 0;
      exp_pc  = 32'h0;
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      reset   = 1'b1;
      mr = req_addr.size();
      md = del_pc.size();
      stray_ack = 1;
      cyc(0, 0, '0);
      stray_ack = 0;
      repeat (10) cyc(0, 0, '0);
      chk("t6_req0", req_addr[mr], 32'h0);
      chk("t6_pc0", del_pc[md], 32'h0);
      chk("t6_ins0", {16'b0, del_ins[md]}, 32'h0211);

      // random traffic against the stream model
      lat_fix  = -1;
      err_en   = 1;
      err_addr = 32'h7C0;
      md = del_pc.size();
      for (int k = 0; k < 2000; k++) begin
         bit          st;
         bit          rd;
         logic [31:0] rpc;
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 24) == 0);
         rpc = ($urandom_range(0, 7) == 0)
               ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
               : ($urandom & 32'h0000_0FFF);
         cyc(st, rd, rpc);
      end
      chk("rand_progress",
          {31'b0, (del_pc.size() - md) > 300}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch and prefetch-queue stage that sits directly upstream of the 16-bit instruction decoder. It issues 32-bit aligned reads to the instruction memory port, splits each returned word into two 16-bit instruction parcels, buffers them in a small FIFO, and presents one parcel per cycle on `ins`/`idone` together with its PC. Branch, jump and trap redirects from execute flush the queue and any in-flight fetch.

## Interface
- `RV`, 32: register/address width.
- `QDEPTH`, 4: parcel queue depth; power of two, ≥ 4.
- `RESET_PC`, 0: fetch address after reset; bit 0 must be 0.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset (low = in reset).
- `stall`  in  1  downstream cannot accept a parcel this cycle.
- `redirect`  in  1  discard everything, restart fetch at `redirect_pc`.
- `redirect_pc`  in  RV  new fetch address; bit 0 ignored.
- `mem_req`  out  1  read request, held until `mem_ack`.
- `mem_addr`  out  RV  word address, bits [1:0] always 0.
- `mem_ack`  in  1  read complete; `mem_rdata`/`mem_err` valid this cycle.
- `mem_rdata`  in  32  read data; parcel at addr+0 in [15:0], addr+2 in [31:16].
- `mem_err`  in  1  bus error on this read.
- `ins`  out  16  instruction parcel to decoder.
- `idone`  out  1  `ins` valid and consumed this cycle.
- `ins_pc`  out  RV  address of `ins`.
- `ifault`  out  1  `ins` came from an errored read (decoder/execute must trap).

## Operation
- Queue entries: {parcel[15:0], pc[RV-1:0], fault}. Head drives `ins`, `ins_pc`, `ifault`.
- `idone = !empty && !stall && !redirect`; a pop occurs exactly when `idone` is 1. No separate handshake: decoder samples on `idone`.
- Fetch PC `fpc` (RV bits, halfword granular). `mem_addr = {fpc[RV-1:2], 2'b00}`.
- Request FSM: IDLE → REQ when no request outstanding and (count after this cycle's push/pop) ≤ QDEPTH-2; REQ holds `mem_req`/`mem_addr` stable until `mem_ack`; on ack → IDLE (or straight back to REQ next cycle if issue condition holds).
- On ack (not discarded): if `fpc[1]==0` push both parcels (pc = fpc, fpc+2); if `fpc[1]==1` push only [31:16] (pc = fpc). `fpc` advances to next word boundary. Fault bit = `mem_err` on each pushed entry.
- After a pushed fault entry, no further requests issue until a redirect.
- Redirect: queue emptied, `fpc = redirect_pc & ~1`. If a request is outstanding and not acked this cycle, set `discard`; the bus request is NOT withdrawn; its ack is dropped (no push), then a new request issues. Ack in the same cycle as redirect is dropped.
- Overflow impossible by issue rule; push and pop in the same cycle allowed. Pointers wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.
- `fpc` wraps modulo 2^RV.

## Timing
- Reset values: `mem_req` 0, `mem_addr` {RESET_PC[RV-1:2],00}, `idone` 0, `ins` 0, `ins_pc` 0, `ifault` 0, queue empty, `discard` 0, `fpc` RESET_PC.
- `mem_req` is registered: first request the cycle after reset deasserts; new request one cycle after issue condition becomes true.
- Acked data is written into the queue on the ack edge; `idone` for it no earlier than the next cycle (see Configuration).
- Redirect: `idone` 0 in the redirect cycle; request for `redirect_pc` visible on `mem_req` the next cycle if no request outstanding.
- Reset asserted mid-transaction: all state returns to reset values immediately; a late `mem_ack` after reset is ignored while `mem_req` is 0.

## Configuration
- `IFETCH_BYPASS_EN`: when defined, an ack arriving while the queue is empty, not stalled and not redirected presents the first parcel on `ins`/`ins_pc`/`ifault` with `idone`=1 in the ack cycle (combinational bypass); only the remaining parcel (if any) is enqueued. Undefined: all parcels go through the queue, minimum ack-to-`idone` latency one cycle.

## Test plan
- Reset release, RESET_PC=0, memory returns 0x44330211 on first ack after 2 wait cycles → `ins` 0x0211 @pc 0, then 0x4433 @pc 2 on consecutive cycles.
- `redirect_pc`=0x106 with empty queue → `mem_addr`=0x104, single parcel [31:16] delivered with `ins_pc`=0x106, next request 0x108.
- `stall` held 10 cycles with QDEPTH=4 → at most 2 requests complete, count stops at 4, no overflow, parcels emerge in order after release.
- Redirect while `mem_req` pending, ack 3 cycles later with 0xDEADBEEF → no parcel from 0xDEADBEEF delivered; next request at new target.
- `mem_err`=1 on ack at 0x20 → two entries with `ifault`=1, `mem_req` stays 0 until redirect.
- With/without `IFETCH_BYPASS_EN`: empty queue, ack → `idone` in ack cycle vs. following cycle.
